// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer
// Write-back buffer that sits between the data cache and data memory. Evicted
// dirty lines are queued in a small FIFO and written to memory one at a time,
// in push order. A push that hits a line already queued (and not currently
// being written) updates that entry in place instead of allocating. Queued
// lines, including the one in flight, are visible to a combinational lookup
// so a dcache miss can be served from the buffer.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   wb_push_i             dcache presents an evicted dirty line
//   wb_addr_i             evicted line address (bits [3:0] ignored)
//   wb_data_i             evicted line data
//   wb_full_o             no free entry, push is dropped
//   wb_empty_o            nothing queued and no memory write in flight
//   wb_count_o            number of valid entries
//   lookup_addr_i         dcache miss address
//   lookup_hit_o          miss line is held in the buffer
//   lookup_data_o         data of the matching entry, 0 on no hit
//   mem_req_o             write request to data memory (head entry)
//   mem_addr_o            head line address, bits [3:0] = 0
//   mem_data_o            head line data
//   mem_ack_i             memory accepted the current write
module dcache_wb_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_push_i,
  input  logic [ADDR_WIDTH-1:0]        wb_addr_i,
  input  logic [LINE_WIDTH-1:0]        wb_data_i,
  output logic                         wb_full_o,
  output logic                         wb_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   wb_count_o,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic [LINE_WIDTH-1:0]        lookup_data_o,
  output logic                         mem_req_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [LINE_WIDTH-1:0]        mem_data_o,
  input  logic                         mem_ack_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = ADDR_WIDTH - 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q;
  logic [TW-1:0]         tag_q  [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;

  logic                  in_flight;
  logic                  push_ok;
  logic                  pop;
  logic                  merge_hit;
  logic [PW-1:0]         merge_idx;
  logic                  do_merge;
  logic                  do_alloc;
  logic                  look_head_hit;
  logic                  look_other_hit;
  logic [LINE_WIDTH-1:0] look_other_data;
  logic                  unused_addr_bits;

  // Byte offset within a line plays no part in matching or memory addressing.
  assign unused_addr_bits = &{1'b0, wb_addr_i[3:0], lookup_addr_i[3:0]};

  assign in_flight = (state_q == BUSY);
  // A full buffer drops the push outright, even when an ack frees a slot in
  // the same cycle; merges are not allowed while full either.
  assign push_ok   = wb_push_i && !wb_full_o;
  assign pop       = in_flight && mem_ack_i;

  // Merge target: a valid entry with the same line, excluding the head while
  // its write is in flight (its data must stay stable until acked).
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == wb_addr_i[ADDR_WIDTH-1:4] &&
          !(in_flight && PW'(i) == head_q)) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end

  assign do_merge   = push_ok && merge_hit;
  assign do_alloc   = push_ok && !merge_hit;
  assign count_next = count_q + CW'(do_alloc) - CW'(pop);

  // Lookup. A line can be present twice only as the in-flight head plus a
  // newer copy pushed after it; the newer copy holds the current data, so it
  // takes priority over the head.
  always_comb begin
    look_head_hit   = 1'b0;
    look_other_hit  = 1'b0;
    look_other_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_addr_i[ADDR_WIDTH-1:4]) begin
        if (in_flight && PW'(i) == head_q) begin
          look_head_hit = 1'b1;
        end else begin
          look_other_hit  = 1'b1;
          look_other_data = data_q[i];
        end
      end
    end
  end

  assign lookup_hit_o  = look_head_hit || look_other_hit;
  assign lookup_data_o = look_other_hit ? look_other_data :
                         look_head_hit  ? data_q[head_q]  : '0;

  assign wb_full_o  = (count_q == CW'(DEPTH));
  assign wb_empty_o = (count_q == '0) && (state_q == IDLE);
  assign wb_count_o = count_q;

  // Memory-side outputs are gated by the state register so they read zero
  // whenever no write is in flight (including straight out of reset).
  assign mem_req_o  = in_flight;
  assign mem_addr_o = in_flight ? {tag_q[head_q], 4'b0000} : '0;
  assign mem_data_o = in_flight ? data_q[head_q] : '0;

  // Control: pointers, valids, count and the write FSM. The FSM is BUSY
  // whenever the buffer will hold at least one entry, which gives a one-cycle
  // push-to-request latency and back-to-back writes while entries remain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_alloc) begin
        tail_q          <= tail_q + PW'(1);
        valid_q[tail_q] <= 1'b1;
      end
      if (pop) begin
        head_q          <= head_q + PW'(1);
        valid_q[head_q] <= 1'b0;
      end
      count_q <= count_next;
      state_q <= (count_next != '0) ? BUSY : IDLE;
    end
  end

  // Entry storage needs no reset; valids qualify every use of it.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      tag_q[tail_q]  <= wb_addr_i[ADDR_WIDTH-1:4];
      data_q[tail_q] <= wb_data_i;
    end
    if (do_merge) begin
      data_q[merge_idx] <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb_dcache_wb_buffer
// Directed, self-checking bench for dcache_wb_buffer (DEPTH=4, 32-bit
// addresses, 128-bit lines). Expected values are hand-computed constants.
module tb_dcache_wb_buffer;

  logic         clk;
  logic         rst_n;
  logic         wb_push_i;
  logic [31:0]  wb_addr_i;
  logic [127:0] wb_data_i;
  logic         wb_full_o;
  logic         wb_empty_o;
  logic [2:0]   wb_count_o;
  logic [31:0]  lookup_addr_i;
  logic         lookup_hit_o;
  logic [127:0] lookup_data_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic         mem_ack_i;

  int testsRun;
  int testsFailed;

  localparam logic [127:0] D0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D1 = 128'hD1D1_0001_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [127:0] D2 = 128'hD2D2_0002_0123_4567_89AB_CDEF_0011_2233;
  localparam logic [127:0] D3 = 128'hD3D3_0003_FEDC_BA98_7654_3210_4455_6677;
  localparam logic [127:0] D4 = 128'hD4D4_0004_1357_9BDF_2468_ACE0_8899_AABB;
  localparam logic [127:0] D5 = 128'hD5D5_0005_CAFE_BABE_DEAD_BEEF_F00D_0001;

  dcache_wb_buffer #(
    .DEPTH(4),
    .ADDR_WIDTH(32),
    .LINE_WIDTH(128)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wb_push_i(wb_push_i),
    .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i),
    .wb_full_o(wb_full_o),
    .wb_empty_o(wb_empty_o),
    .wb_count_o(wb_count_o),
    .lookup_addr_i(lookup_addr_i),
    .lookup_hit_o(lookup_hit_o),
    .lookup_data_o(lookup_data_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic push, input logic [31:0] addr,
                               input logic [127:0] data, input logic ack);
    wb_push_i = push;
    wb_addr_i = addr;
    wb_data_i = data;
    mem_ack_i = ack;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLookup(input logic [31:0] addr);
    lookup_addr_i = addr;
    #1;
  endtask

  initial begin
    logic [31:0] drainAddr [4];
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    lookup_addr_i = 32'h0;
    applyStimulus(1'b0, 32'h0, '0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_mem_req",   128'(mem_req_o),     128'h0);
    checkOutput("rst_mem_addr",  128'(mem_addr_o),    128'h0);
    checkOutput("rst_mem_data",  mem_data_o,          128'h0);
    checkOutput("rst_full",      128'(wb_full_o),     128'h0);
    checkOutput("rst_empty",     128'(wb_empty_o),    128'h1);
    checkOutput("rst_count",     128'(wb_count_o),    128'h0);
    checkOutput("rst_hit",       128'(lookup_hit_o),  128'h0);
    checkOutput("rst_look_data", lookup_data_o,       128'h0);
    rst_n = 1'b1;
    tick();

    // Ack while idle is ignored
    applyStimulus(1'b0, 32'h0, '0, 1'b1);
    tick();
    checkOutput("idle_ack_count", 128'(wb_count_o), 128'h0);
    checkOutput("idle_ack_empty", 128'(wb_empty_o), 128'h1);
    // Push into empty with ack already high: ack ignored this edge
    applyStimulus(1'b1, 32'h0000_9000, D5, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, '0, 1'b1);
    checkOutput("idle_ack_push_count", 128'(wb_count_o), 128'h1);
    checkOutput("idle_ack_push_req",   128'(mem_req_o),  128'h1);
    tick();
    applyStimulus(1'b0, 32'h0, '0, 1'b0);
    checkOutput("idle_ack_pop_empty", 128'(wb_empty_o), 128'h1);

    // Single push, ack three cycles later
    applyStimulus(1'b1, 32'h0000_1000, D0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, '0, 1'b0);
    checkOutput("single_req",   128'(mem_req_o),  128'h1);
    checkOutput("single_count", 128'(wb_count_o), 128'h1);
    checkOutput("single_empty", 128'(wb_empty_o), 128'h0);
    checkOutput("single_data",  mem_data_o,       D0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("single_addr_c%0d", c), 128'(mem_addr_o), 128'h1000);
      if (c < 2) tick();
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("single_done_req",   128'(mem_req_o),  128'h0);
    checkOutput("single_done_empty", 128'(wb_empty_o), 128'h1);

    // Fill beyond capacity, then drain in push order
    drainAddr[0] = 32'h5000;
    drainAddr[1] = 32'h501C;
    drainAddr[2] = 32'h5020;
    drainAddr[3] = 32'h5030;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, drainAddr[i], 128'(i + 16), 1'b0);
      tick();
    end
    checkOutput("fill_full", 128'(wb_full_o), 128'h1);
    applyStimulus(1'b1, 32'h5040, 128'h99, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, '0, 1'b0);
    checkOutput("fill_drop_count", 128'(wb_count_o), 128'h4);
    setLookup(32'h5040);
    checkOutput("fill_drop_hit", 128'(lookup_hit_o), 128'h0);
    setLookup(32'h5034);
    checkOutput("fill_last_hit",  128'(lookup_hit_o), 128'h1);
    checkOutput("fill_last_data", lookup_data_o,      128'h13);
    mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_addr%0d", i), 128'(mem_addr_o),
                  128'(drainAddr[i] & 32'hFFFF_FFF0));
      checkOutput($sformatf("drain_data%0d", i), mem_data_o, 128'(i + 16));
      tick();
    end
    mem_ack_i = 1'b0;
    checkOutput("drain_empty", 128'(wb_empty_o), 128'h1);

    // Full buffer, push and ack in the same cycle: push dropped
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h6000 + 32'(i * 16), 128'(i + 32), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'h6040, 128'h77, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, '0, 1'b0);
    checkOutput("full_pushpop_count", 128'(wb_count_o), 128'h3);
    checkOutput("full_pushpop_full",  128'(wb_full_o),  128'h0);
    setLookup(32'h6040);
    checkOutput("full_pushpop_hit", 128'(lookup_hit_o), 128'h0);
    mem_ack_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("full_drain_addr%0d", i), 128'(mem_addr_o),
                  128'(32'h6000 + 32'(i * 16)));
      tick();
    end
    mem_ack_i = 1'b0;
    checkOutput("full_drain_empty", 128'(wb_empty_o), 128'h1);

    // Merge into a queued non-head entry, lookup around the ack edge
    applyStimulus(1'b1, 32'h2000, D1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h3000, D2, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h3004, D3, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, '0, 1'b0);
    checkOutput("merge_count", 128'(wb_count_o), 128'h2);
    setLookup(32'h200C);
    checkOutput("look_inflight_hit",  128'(lookup_hit_o), 128'h1);
    checkOutput("look_inflight_data", lookup_data_o,      D1);
    setLookup(32'h3008);
    checkOutput("look_merged_data", lookup_data_o, D3);
    checkOutput("merge_head_addr", 128'(mem_addr_o), 128'h2000);
    checkOutput("merge_head_data", mem_data_o,       D1);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    setLookup(32'h200C);
    checkOutput("look_after_ack_hit",  128'(lookup_hit_o), 128'h0);
    checkOutput("look_after_ack_data", lookup_data_o,      128'h0);
    checkOutput("merge_next_addr", 128'(mem_addr_o), 128'h3000);
    checkOutput("merge_next_data", mem_data_o,       D3);
    checkOutput("merge_next_count", 128'(wb_count_o), 128'h1);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("merge_empty", 128'(wb_empty_o), 128'h1);

    // Push matching the in-flight head allocates a new entry
    applyStimulus(1'b1, 32'h8000, D4, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8004, D5, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, '0, 1'b0);
    checkOutput("head_alloc_count", 128'(wb_count_o), 128'h2);
    checkOutput("head_alloc_data0", mem_data_o,       D4);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("head_alloc_addr1", 128'(mem_addr_o), 128'h8000);
    checkOutput("head_alloc_data1", mem_data_o,       D5);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("head_alloc_empty", 128'(wb_empty_o), 128'h1);

    // Reset mid-transaction with three entries queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h7000 + 32'(i * 16), 128'(i + 48), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, '0, 1'b0);
    checkOutput("pre_rst_count", 128'(wb_count_o), 128'h3);
    checkOutput("pre_rst_req",   128'(mem_req_o),  128'h1);
    rst_n = 1'b0;
    setLookup(32'h7000);
    tick();
    checkOutput("mid_rst_req",       128'(mem_req_o),    128'h0);
    checkOutput("mid_rst_addr",      128'(mem_addr_o),   128'h0);
    checkOutput("mid_rst_data",      mem_data_o,         128'h0);
    checkOutput("mid_rst_full",      128'(wb_full_o),    128'h0);
    checkOutput("mid_rst_empty",     128'(wb_empty_o),   128'h1);
    checkOutput("mid_rst_count",     128'(wb_count_o),   128'h0);
    checkOutput("mid_rst_hit",       128'(lookup_hit_o), 128'h0);
    checkOutput("mid_rst_look_data", lookup_data_o,      128'h0);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_req",   128'(mem_req_o),  128'h0);
    checkOutput("post_rst_count", 128'(wb_count_o), 128'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dcache_wb_buffer.md
DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered evicted lines (power of two, >=2).
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter LINE_WIDTH, default 128, cache line width in bits; line offset is 4 address bits.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 wb_push_i  input  1  dcache presents an evicted dirty line.
REQ-007 wb_addr_i  input  ADDR_WIDTH  line address of the evicted line; bits [3:0] ignored.
REQ-008 wb_data_i  input  LINE_WIDTH  evicted line data.
REQ-009 wb_full_o  output  1  no free entry; push not accepted.
REQ-010 wb_empty_o  output  1  no valid entry and no memory write in flight.
REQ-011 wb_count_o  output  $clog2(DEPTH+1)  number of valid entries.
REQ-012 lookup_addr_i  input  ADDR_WIDTH  dcache miss address to check against buffered lines.
REQ-013 lookup_hit_o  output  1  lookup line address matches a valid entry.
REQ-014 lookup_data_o  output  LINE_WIDTH  data of matching entry; 0 when no hit.
REQ-015 mem_req_o  output  1  write request to data memory.
REQ-016 mem_addr_o  output  ADDR_WIDTH  head entry line address, bits [3:0] = 0.
REQ-017 mem_data_o  output  LINE_WIDTH  head entry data.
REQ-018 mem_ack_i  input  1  memory accepted the current write.

Function
REQ-019 Entries SHALL form a FIFO; memory writes issue strictly in push order, except merges (REQ-021).
REQ-020 Push SHALL be accepted when wb_push_i=1 and wb_full_o=0; when full, push SHALL be dropped with no state change, even if an ack pops in the same cycle.
REQ-021 Push whose line address (bits [ADDR_WIDTH-1:4]) matches a valid non-head-in-flight entry SHALL overwrite that entry's data in place; count unchanged.
REQ-022 Push matching the head while mem_req_o=1 SHALL allocate a new entry.
REQ-023 wb_full_o SHALL equal (count==DEPTH); wb_count_o SHALL reflect registered count.
REQ-024 Write FSM states: IDLE, BUSY.
REQ-025 IDLE -> BUSY on the edge when count becomes or is nonzero; mem_req_o=1 exactly in BUSY.
REQ-026 In BUSY, mem_addr_o/mem_data_o SHALL remain stable until mem_ack_i=1.
REQ-027 On mem_ack_i=1 in BUSY: head popped; if entries remain, stay BUSY presenting the next head the following cycle; else go to IDLE.
REQ-028 mem_ack_i in IDLE SHALL be ignored.
REQ-029 Latency: push into empty buffer -> mem_req_o=1 on the next cycle.
REQ-030 Simultaneous accepted push and pop: count unchanged; pointers both advance.
REQ-031 Lookup SHALL be combinational on line address; head in flight remains hittable until its ack edge.
REQ-032 Pointers SHALL wrap modulo DEPTH.
REQ-033 wb_empty_o SHALL equal (count==0) and state==IDLE.

Reset
REQ-034 On rst_n=0 at a clock edge: count, pointers, entry valids = 0; state = IDLE.
REQ-035 Reset values: mem_req_o=0, mem_addr_o=0, mem_data_o=0, wb_full_o=0, wb_empty_o=1, wb_count_o=0, lookup_hit_o=0, lookup_data_o=0.
REQ-036 Reset mid-transaction SHALL discard all entries including the in-flight write; mem_req_o low from the first reset cycle.

Verification
REQ-037 Push addr 0x1000 data D0 into empty buffer, ack 3 cycles later -> mem_req_o=1 next cycle, addr 0x1000 stable 3 cycles, then IDLE, wb_empty_o=1.
REQ-038 Push 5 distinct lines with DEPTH=4, no ack -> 4 accepted, wb_full_o=1, 5th dropped; acks drain in push order.
REQ-039 Push 0x2000 D1, 0x3000 D2, then 0x3004 D3 with head 0x2000 in flight -> count stays 2, memory sees 0x2000/D1 then 0x3000/D3.
REQ-040 Lookup 0x200C while 0x2000 in flight -> hit, data D1; lookup after ack edge -> hit=0, data 0.
REQ-041 Full buffer, push and ack same cycle -> push dropped, count 3.
REQ-042 Assert rst_n=0 with mem_req_o=1 and 3 entries -> all outputs at REQ-035 values, no further mem_req_o.
